// File: rtl/hsi_encoder_if.sv
// Byte write port of the HSI transmitter: data/last with a write strobe.
// The encoder signals back through ready; a write is taken only while ready is high.
interface hsi_encoder_if;
    logic [7:0] data;
    logic       last;
    logic       wr;
    logic       ready;

    modport master (output data, output last, output wr, input ready);
    modport slave  (input data, input last, input wr, output ready);
endinterface

// File: rtl/hsi_encoder.sv
// HSI line transmitter: frames bytes as start/8 data/parity/stop at BIT_TICKS clk_en ticks per bit.
// A start bit follows one tick after a byte is held; ready drops while the one-byte holding register is full.
`ifndef LSB
`define LSB 0
`endif
`ifndef ML_FST
`define ML_FST `LSB
`endif

module hsi_encoder #(
    parameter int BIT_TICKS = 8,
    parameter int GAP_BITS  = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clk_en,
    hsi_encoder_if.slave bus,
    output logic         q,
    output logic         busy,
    output logic         msg_done,
    output logic         underrun
);

    // The build normally takes ML_FST from hsi_config.vh; the defaults above give LSB first.
    localparam bit LSB_FIRST = (`ML_FST == `LSB);

    localparam int GAP_TICKS = GAP_BITS * BIT_TICKS;
    localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int GW        = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);
    localparam logic [3:0]    STOP_IDX  = 4'd10;

    typedef enum logic [1:0] {IDLE, FRAME, STALL, GAP} state_t;

    state_t        state, state_nx;
    logic [7:0]    hold_dat;
    logic          hold_last;
    logic          hold_full;
    logic [7:0]    frame_dat;
    logic          frame_last;
    logic [TW-1:0] tick_cnt, tick_nx;
    logic [3:0]    bit_idx, idx_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic          q_nx, busy_nx, done_nx, under_nx;
    logic          take;

    assign bus.ready = ~hold_full;

    function automatic logic line_bit(input logic [3:0] idx, input logic [7:0] d);
        logic [2:0] k;
        k = 3'(idx - 4'd1);
        case (idx)
            4'd0:    line_bit = 1'b0;
            4'd9:    line_bit = ~^d;
            4'd10:   line_bit = 1'b1;
            default: line_bit = LSB_FIRST ? d[k] : d[3'd7 - k];
        endcase
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_dat   <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            frame_dat  <= '0;
            frame_last <= 1'b0;
        end else if (take) begin
            hold_full  <= 1'b0;
            frame_dat  <= hold_dat;
            frame_last <= hold_last;
        end else if (bus.wr && !hold_full) begin
            hold_dat  <= bus.data;
            hold_last <= bus.last;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            q        <= 1'b1;
            busy     <= 1'b0;
            msg_done <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            bit_idx  <= idx_nx;
            gap_cnt  <= gap_nx;
            q        <= q_nx;
            busy     <= busy_nx;
            msg_done <= done_nx;
            underrun <= under_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        idx_nx   = bit_idx;
        gap_nx   = gap_cnt;
        q_nx     = q;
        busy_nx  = busy;
        done_nx  = 1'b0;
        under_nx = 1'b0;
        take     = 1'b0;
        if (clk_en) begin
            case (state)
                IDLE, STALL: begin
                    if (hold_full) begin
                        take     = 1'b1;
                        state_nx = FRAME;
                        q_nx     = 1'b0;
                        busy_nx  = 1'b1;
                        tick_nx  = '0;
                        idx_nx   = '0;
                    end
                end
                FRAME: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nx = '0;
                        if (bit_idx == STOP_IDX) begin
                            // Last frame wins over a held byte: that byte opens the next message.
                            if (frame_last) begin
                                state_nx = GAP;
                                gap_nx   = '0;
                                q_nx     = 1'b1;
                            end else if (hold_full) begin
                                take   = 1'b1;
                                q_nx   = 1'b0;
                                idx_nx = '0;
                            end else begin
                                state_nx = STALL;
                                under_nx = 1'b1;
                                q_nx     = 1'b1;
                            end
                        end else begin
                            idx_nx = bit_idx + 4'd1;
                            q_nx   = line_bit(bit_idx + 4'd1, frame_dat);
                        end
                    end else begin
                        tick_nx = tick_cnt + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        gap_nx   = '0;
                    end else begin
                        gap_nx = gap_cnt + GW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsi_encoder.sv
// Scoreboard bench for hsi_encoder: stimulus queues expected frames/events, a line monitor decodes and checks them.
`ifndef LSB
`define LSB 0
`endif
`ifndef ML_FST
`define ML_FST `LSB
`endif

module tb_hsi_encoder;

    localparam bit LSB_FIRST = (`ML_FST == `LSB);
    localparam logic [1:0] EV_DONE  = 2'b10;
    localparam logic [1:0] EV_UNDER = 2'b01;

    typedef struct {
        logic [10:0] bits;
        int          spacing;
    } frm_t;

    typedef struct {
        logic [1:0] kind;
        int         off;
    } ev_t;

    logic clk;
    logic n_rst;
    logic clk_en;
    logic q, busy, msg_done, underrun;
    logic en_at_edge;
    int   tick_no;
    int   en_div;
    int   checks;
    int   errors;

    frm_t exp_q[$];
    ev_t  ev_q[$];

    hsi_encoder_if bus();

    hsi_encoder #(.BIT_TICKS(8), .GAP_BITS(2)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .clk_en   (clk_en),
        .bus      (bus),
        .q        (q),
        .busy     (busy),
        .msg_done (msg_done),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int cyc;
        cyc    = 0;
        clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            clk_en = ((cyc % en_div) == 0);
        end
    end

    initial tick_no = 0;
    always @(posedge clk) begin
        en_at_edge <= clk_en & n_rst;
        if (clk_en && n_rst) tick_no <= tick_no + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic par, input int spacing);
        frm_t f;
        f.bits[0] = 1'b0;
        for (int k = 1; k <= 8; k++) f.bits[k] = LSB_FIRST ? d[k-1] : d[8-k];
        f.bits[9]  = par;
        f.bits[10] = 1'b1;
        f.spacing  = spacing;
        exp_q.push_back(f);
    endtask

    task automatic expect_ev(input logic [1:0] kind, input int off);
        ev_t e;
        e.kind = kind;
        e.off  = off;
        ev_q.push_back(e);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) fail_now("write_ready_timeout");
        bus.wr   = 1'b1;
        bus.data = d;
        bus.last = l;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy === 1'b0 && bus.ready === 1'b1 && exp_q.size() == 0 && ev_q.size() == 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) fail_now("idle_timeout");
    endtask

    // Line monitor: decodes frames from mid-bit samples and matches pulses against queued events.
    initial begin
        bit          in_frame;
        int          fstart, prev_start, off;
        logic [10:0] rx;
        frm_t        f;
        ev_t         e;
        in_frame   = 1'b0;
        fstart     = 0;
        prev_start = 0;
        rx         = '0;
        forever begin
            @(negedge clk);
            if (n_rst !== 1'b1) begin
                in_frame = 1'b0;
                continue;
            end
            if (en_at_edge) begin
                if (!in_frame && q === 1'b0) begin
                    in_frame = 1'b1;
                    fstart   = tick_no;
                    rx       = '0;
                    chk("busy_at_start", int'(busy), 1);
                    if (exp_q.size() > 0 && exp_q[0].spacing != 0)
                        chk("frame_spacing", tick_no - prev_start, exp_q[0].spacing);
                    prev_start = tick_no;
                end
                if (in_frame) begin
                    off = tick_no - fstart;
                    if (off % 8 == 4) rx[off/8] = q;
                    if (off == 84) begin
                        in_frame = 1'b0;
                        if (exp_q.size() == 0) fail_now("unexpected_frame");
                        else begin
                            f = exp_q.pop_front();
                            chk("frame_bits", int'(rx), int'(f.bits));
                        end
                    end
                end
            end
            if (msg_done === 1'b1 || underrun === 1'b1) begin
                chk("pulse_on_tick", int'(en_at_edge), 1);
                if (ev_q.size() == 0) fail_now("unexpected_event");
                else begin
                    e = ev_q.pop_front();
                    chk("event_kind", int'({msg_done, underrun}), int'(e.kind));
                    chk("event_offset", tick_no - fstart, e.off);
                    chk("busy_at_event", int'(busy), (e.kind == EV_DONE) ? 0 : 1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int fall, rise, n;
        checks   = 0;
        errors   = 0;
        en_div   = 1;
        n_rst    = 1'b0;
        bus.wr   = 1'b0;
        bus.data = '0;
        bus.last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", int'(q), 1);
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_msg_done", int'(msg_done), 0);
        chk("rst_underrun", int'(underrun), 0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // single byte, last
        expect_frame(8'hA5, 1'b1, 0);
        expect_ev(EV_DONE, 104);
        write_byte(8'hA5, 1'b1);
        wait_idle();

        // two-byte message, back to back
        expect_frame(8'h00, 1'b1, 0);
        expect_frame(8'hFF, 1'b1, 88);
        expect_ev(EV_DONE, 104);
        write_byte(8'h00, 1'b0);
        write_byte(8'hFF, 1'b1);
        wait_idle();

        // underrun, then resume within the same message
        expect_frame(8'h3C, 1'b1, 0);
        expect_ev(EV_UNDER, 88);
        write_byte(8'h3C, 1'b0);
        n = 0;
        while (ev_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) fail_now("underrun_timeout");
        repeat (30) @(posedge clk);
        #1;
        chk("stall_q_high", int'(q), 1);
        chk("stall_busy", int'(busy), 1);
        expect_frame(8'h01, 1'b0, 0);
        expect_ev(EV_DONE, 104);
        write_byte(8'h01, 1'b1);
        @(posedge clk);
        #1;
        chk("resume_next_tick_q", int'(q), 0);
        chk("resume_busy", int'(busy), 1);
        wait_idle();

        // handshake: ignored write while full, clk_en every 3rd clk
        en_div = 3;
        expect_frame(8'h81, 1'b1, 0);
        expect_ev(EV_DONE, 104);
        write_byte(8'h81, 1'b1);
        chk("ready_low_after_wr", int'(bus.ready), 0);
        bus.wr   = 1'b1;
        bus.data = 8'h55;
        bus.last = 1'b1;
        fall = -1;
        rise = -1;
        for (int c = 1; c <= 400 && rise < 0; c++) begin
            @(posedge clk);
            #1;
            bus.wr = 1'b0;
            if (fall < 0 && q === 1'b0) fall = c;
            else if (fall >= 0 && q === 1'b1) rise = c;
        end
        chk("bit_period_clk", rise - fall, 24);
        wait_idle();
        en_div = 1;
        repeat (3) @(posedge clk);
        #1;

        // reset mid-frame drops both the frame and the held byte
        write_byte(8'h5A, 1'b1);
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail_now("busy_rise_timeout");
        write_byte(8'h33, 1'b1);
        repeat (39) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("midrst_q", int'(q), 1);
        chk("midrst_ready", int'(bus.ready), 1);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        chk("post_rst_q_idle", int'(q), 1);
        chk("post_rst_busy", int'(busy), 0);
        expect_frame(8'hC3, 1'b1, 0);
        expect_ev(EV_DONE, 104);
        write_byte(8'hC3, 1'b1);
        wait_idle();

        // single high bit: its position depends on the bit-order build
        expect_frame(8'h80, 1'b0, 0);
        expect_ev(EV_DONE, 104);
        write_byte(8'h80, 1'b1);
        wait_idle();

        repeat (20) @(posedge clk);
        #1;
        chk("frames_left", exp_q.size(), 0);
        chk("events_left", ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
